// File: rtl/tl_ac_channel_arbiter_if.sv
// TileLink A/C merge bundle: the A and C source channels plus the merged
// stream toward the TL-to-AXI bridge. The arbiter uses the slave modport.
interface tl_ac_channel_arbiter_if #(
    parameter int unsigned BW_DATA   = 32,
    parameter int unsigned BW_ADDR   = 32,
    parameter int unsigned BW_SOURCE = 2,
    parameter int unsigned BW_SIZE   = 4
);
    localparam int unsigned BW_MASK = BW_DATA / 8;

    // A channel (Get/Put/Acquire)
    logic                 a_valid;
    logic                 a_ready;
    logic [2:0]           a_opcode;
    logic [2:0]           a_param;
    logic [BW_SIZE-1:0]   a_size;
    logic [BW_SOURCE-1:0] a_source;
    logic [BW_ADDR-1:0]   a_address;
    logic [BW_MASK-1:0]   a_mask;
    logic [BW_DATA-1:0]   a_data;

    // C channel (ProbeAck/Release), no mask
    logic                 c_valid;
    logic                 c_ready;
    logic [2:0]           c_opcode;
    logic [2:0]           c_param;
    logic [BW_SIZE-1:0]   c_size;
    logic [BW_SOURCE-1:0] c_source;
    logic [BW_ADDR-1:0]   c_address;
    logic [BW_DATA-1:0]   c_data;

    // Merged stream
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_chan;
    logic [2:0]           m_opcode;
    logic [2:0]           m_param;
    logic [BW_SIZE-1:0]   m_size;
    logic [BW_SOURCE-1:0] m_source;
    logic [BW_ADDR-1:0]   m_address;
    logic [BW_MASK-1:0]   m_mask;
    logic [BW_DATA-1:0]   m_data;
    logic                 m_first;
    logic                 m_last;

    // Arbiter side
    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        input  c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data,
        output c_ready,
        output m_valid, m_chan, m_opcode, m_param, m_size, m_source, m_address,
               m_mask, m_data, m_first, m_last,
        input  m_ready
    );

    // Tile / bridge side
    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        output c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data,
        input  c_ready,
        input  m_valid, m_chan, m_opcode, m_param, m_size, m_source, m_address,
               m_mask, m_data, m_first, m_last,
        output m_ready
    );
endinterface

// File: rtl/tl_ac_channel_arbiter.sv
// Merges the TileLink A and C channels into one message stream. Grants change
// only at message boundaries; multi-beat messages are never interleaved.
// Datapath and ready regeneration are combinational; grant/state/count are
// registered.
module tl_ac_channel_arbiter #(
    parameter int unsigned BW_DATA       = 32,
    parameter int unsigned BW_ADDR       = 32,
    parameter int unsigned BW_SOURCE     = 2,
    parameter int unsigned BW_SIZE       = 4,
    parameter int unsigned MAX_SIZE_LOG2 = 6,
    parameter bit          C_PRIORITY    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rstnn,
    tl_ac_channel_arbiter_if.slave  bus,
    output logic                    err_oversize
);
    localparam int unsigned BW_MASK    = BW_DATA / 8;
    localparam int unsigned BYTES_LOG2 = $clog2(BW_MASK);
    localparam int unsigned CNT_W      = MAX_SIZE_LOG2 - BYTES_LOG2 + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] BURST = 2'd2;

    localparam logic CH_A = 1'b0;
    localparam logic CH_C = 1'b1;

    logic [1:0]       state, state_nxt;
    logic             gnt_chan, gnt_chan_nxt;
    logic             rr_last, rr_last_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic             err_nxt;

    logic             pick_chan;
    logic             sel_chan;
    logic             sel_valid;
    logic [2:0]       sel_opcode;
    logic [BW_SIZE-1:0] sel_size;
    logic             sel_has_data;
    logic             sel_oversize;
    logic [31:0]      size_clamp;
    logic [CNT_W-1:0] sel_beats;
    logic             granted;

    // Boundary arbitration among currently valid channels
    always_comb begin
        pick_chan = CH_A;
        if (bus.a_valid && bus.c_valid) begin
            pick_chan = C_PRIORITY ? CH_C : ~rr_last;
        end else if (bus.c_valid) begin
            pick_chan = CH_C;
        end
    end

    // Grant is live arbitration in IDLE, frozen otherwise
    assign sel_chan  = (state == IDLE) ? pick_chan : gnt_chan;
    assign sel_valid = (sel_chan == CH_C) ? bus.c_valid : bus.a_valid;
    assign granted   = (state != IDLE) || sel_valid;

    assign sel_opcode = (sel_chan == CH_C) ? bus.c_opcode : bus.a_opcode;
    assign sel_size   = (sel_chan == CH_C) ? bus.c_size   : bus.a_size;

    // Beat count of the message at the head of the granted channel
    always_comb begin
        sel_has_data = (sel_chan == CH_C) ? sel_opcode[0] : ~sel_opcode[2];
        sel_oversize = 32'(sel_size) > 32'(MAX_SIZE_LOG2);
        size_clamp   = sel_oversize ? 32'(MAX_SIZE_LOG2) : 32'(sel_size);
        sel_beats    = CNT_W'(1);
        if (sel_has_data && (size_clamp > 32'(BYTES_LOG2))) begin
            sel_beats = CNT_W'(1) << (size_clamp - 32'(BYTES_LOG2));
        end
    end

    // Merged payload and handshake pass-through
    always_comb begin
        bus.m_valid   = sel_valid;
        bus.m_chan    = sel_chan;
        bus.m_opcode  = sel_opcode;
        bus.m_size    = sel_size;
        bus.m_param   = (sel_chan == CH_C) ? bus.c_param   : bus.a_param;
        bus.m_source  = (sel_chan == CH_C) ? bus.c_source  : bus.a_source;
        bus.m_address = (sel_chan == CH_C) ? bus.c_address : bus.a_address;
        bus.m_data    = (sel_chan == CH_C) ? bus.c_data    : bus.a_data;
        bus.m_mask    = (sel_chan == CH_C) ? {BW_MASK{1'b1}} : bus.a_mask;
        bus.a_ready   = granted && (sel_chan == CH_A) && bus.m_ready;
        bus.c_ready   = granted && (sel_chan == CH_C) && bus.m_ready;
        bus.m_first   = (state != BURST);
        if (state == BURST) begin
            bus.m_last = (beat_cnt == CNT_W'(1));
        end else begin
            bus.m_last = sel_valid && (sel_beats == CNT_W'(1));
        end
    end

    // Next-state, grant, beat counter, rr pointer and sticky error
    always_comb begin
        state_nxt    = state;
        gnt_chan_nxt = gnt_chan;
        rr_last_nxt  = rr_last;
        beat_cnt_nxt = beat_cnt;
        err_nxt      = err_oversize;
        case (state)
            IDLE, HOLD: begin
                if (sel_valid) begin
                    gnt_chan_nxt = sel_chan;
                    if (bus.m_ready) begin
                        if (sel_oversize) begin
                            err_nxt = 1'b1;
                        end
                        if (sel_beats > CNT_W'(1)) begin
                            state_nxt    = BURST;
                            beat_cnt_nxt = sel_beats - CNT_W'(1);
                        end else begin
                            state_nxt   = IDLE;
                            rr_last_nxt = sel_chan;
                        end
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end
            BURST: begin
                if (sel_valid && bus.m_ready) begin
                    beat_cnt_nxt = beat_cnt - CNT_W'(1);
                    if (beat_cnt == CNT_W'(1)) begin
                        state_nxt   = IDLE;
                        rr_last_nxt = gnt_chan;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state        <= IDLE;
            gnt_chan     <= CH_A;
            rr_last      <= CH_A;
            beat_cnt     <= '0;
            err_oversize <= 1'b0;
        end else begin
            state        <= state_nxt;
            gnt_chan     <= gnt_chan_nxt;
            rr_last      <= rr_last_nxt;
            beat_cnt     <= beat_cnt_nxt;
            err_oversize <= err_nxt;
        end
    end
endmodule

// File: tb/tb_tl_ac_channel_arbiter.sv
// Directed bench for tl_ac_channel_arbiter. Two instances share stimulus:
// dut_p with C priority and dut_r with round-robin arbitration.
module tb_tl_ac_channel_arbiter;
    logic clk = 1'b0;
    logic rstnn;

    logic        a_valid;
    logic [2:0]  a_opcode, a_param;
    logic [3:0]  a_size;
    logic [1:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        c_valid;
    logic [2:0]  c_opcode, c_param;
    logic [3:0]  c_size;
    logic [1:0]  c_source;
    logic [31:0] c_address;
    logic [31:0] c_data;
    logic        m_ready;
    logic        err_p, err_r;

    int checks = 0;
    int errors = 0;

    tl_ac_channel_arbiter_if #(.BW_DATA(32), .BW_ADDR(32), .BW_SOURCE(2), .BW_SIZE(4)) ifp ();
    tl_ac_channel_arbiter_if #(.BW_DATA(32), .BW_ADDR(32), .BW_SOURCE(2), .BW_SIZE(4)) ifr ();

    assign {ifp.a_valid, ifp.a_opcode, ifp.a_param, ifp.a_size, ifp.a_source, ifp.a_address, ifp.a_mask, ifp.a_data}
         = {a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data};
    assign {ifr.a_valid, ifr.a_opcode, ifr.a_param, ifr.a_size, ifr.a_source, ifr.a_address, ifr.a_mask, ifr.a_data}
         = {a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data};
    assign {ifp.c_valid, ifp.c_opcode, ifp.c_param, ifp.c_size, ifp.c_source, ifp.c_address, ifp.c_data}
         = {c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data};
    assign {ifr.c_valid, ifr.c_opcode, ifr.c_param, ifr.c_size, ifr.c_source, ifr.c_address, ifr.c_data}
         = {c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data};
    assign ifp.m_ready = m_ready;
    assign ifr.m_ready = m_ready;

    tl_ac_channel_arbiter #(
        .BW_DATA(32), .BW_ADDR(32), .BW_SOURCE(2), .BW_SIZE(4),
        .MAX_SIZE_LOG2(6), .C_PRIORITY(1'b1)
    ) dut_p (
        .clk(clk), .rstnn(rstnn), .bus(ifp), .err_oversize(err_p)
    );

    tl_ac_channel_arbiter #(
        .BW_DATA(32), .BW_ADDR(32), .BW_SOURCE(2), .BW_SIZE(4),
        .MAX_SIZE_LOG2(6), .C_PRIORITY(1'b0)
    ) dut_r (
        .clk(clk), .rstnn(rstnn), .bus(ifr), .err_oversize(err_r)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        a_valid = 1'b0; a_opcode = 3'd4; a_param = 3'd0; a_size = 4'd2; a_source = 2'd0;
        a_address = 32'h0; a_mask = 4'hF; a_data = 32'h0;
        c_valid = 1'b0; c_opcode = 3'd4; c_param = 3'd0; c_size = 4'd6; c_source = 2'd0;
        c_address = 32'h0; c_data = 32'h0;
        m_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstnn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstnn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstnn = 1'b0;
        #1;
        checks++;
        if ({ifp.m_valid, ifp.a_ready, ifp.c_ready, ifp.m_first, ifp.m_last, ifp.m_chan, err_p} !== 7'b0001000) begin
            errors++;
            $display("FAIL reset_outputs got v%b ar%b cr%b f%b l%b ch%b err%b expected 0 0 0 1 0 0 0",
                     ifp.m_valid, ifp.a_ready, ifp.c_ready, ifp.m_first, ifp.m_last, ifp.m_chan, err_p);
        end
        repeat (2) @(posedge clk);
        #1 rstnn = 1'b1;
        @(negedge clk);
        checks++;
        if ({ifp.m_valid, ifp.m_first, ifp.m_last} !== 3'b010) begin
            errors++;
            $display("FAIL reset_release got v%b f%b l%b expected 0 1 0", ifp.m_valid, ifp.m_first, ifp.m_last);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_get();
        a_valid = 1'b1; a_opcode = 3'd4; a_size = 4'd2; a_source = 2'd1; a_address = 32'h1000;
        m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({ifp.m_valid, ifp.m_chan, ifp.m_first, ifp.m_last, ifp.a_ready, ifp.c_ready} !== 6'b101110) begin
            errors++;
            $display("FAIL single_get_hs got v%b ch%b f%b l%b ar%b cr%b expected 1 0 1 1 1 0",
                     ifp.m_valid, ifp.m_chan, ifp.m_first, ifp.m_last, ifp.a_ready, ifp.c_ready);
        end
        checks++;
        if (ifp.m_opcode !== 3'd4 || ifp.m_address !== 32'h1000 || ifp.m_source !== 2'd1 || ifp.m_size !== 4'd2) begin
            errors++;
            $display("FAIL single_get_payload got op%0d addr%h src%0d size%0d expected op4 addr00001000 src1 size2",
                     ifp.m_opcode, ifp.m_address, ifp.m_source, ifp.m_size);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({ifp.m_valid, ifp.m_first, ifp.m_last, ifp.a_ready} !== 4'b0100) begin
            errors++;
            $display("FAIL single_get_idle got v%b f%b l%b ar%b expected 0 1 0 0",
                     ifp.m_valid, ifp.m_first, ifp.m_last, ifp.a_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_burst_a();
        logic exp_first, exp_last;
        a_valid = 1'b1; a_opcode = 3'd0; a_size = 4'd6; a_source = 2'd2; a_address = 32'h4000;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_data = 32'(i);
            if (i == 2) begin
                c_valid = 1'b1; c_opcode = 3'd4; c_size = 4'd6; c_source = 2'd3;
                c_address = 32'h2000; c_data = 32'hC0C0;
            end
            @(negedge clk);
            exp_first = (i == 0);
            exp_last  = (i == 15);
            checks++;
            if (ifp.m_chan !== 1'b0 || ifp.a_ready !== 1'b1 || ifp.c_ready !== 1'b0 ||
                ifp.m_first !== exp_first || ifp.m_last !== exp_last || ifp.m_data !== 32'(i)) begin
                errors++;
                $display("FAIL burst_a_beat%0d got ch%b ar%b cr%b f%b l%b d%h expected 0 1 0 %b %b %h",
                         i, ifp.m_chan, ifp.a_ready, ifp.c_ready, ifp.m_first, ifp.m_last, ifp.m_data,
                         exp_first, exp_last, 32'(i));
            end
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({ifp.m_valid, ifp.m_chan, ifp.c_ready, ifp.m_first, ifp.m_last} !== 5'b11111 ||
            ifp.m_data !== 32'hC0C0 || ifp.m_mask !== 4'hF) begin
            errors++;
            $display("FAIL burst_a_c_follow got v%b ch%b cr%b f%b l%b d%h mask%h expected 1 1 1 1 1 0000c0c0 f",
                     ifp.m_valid, ifp.m_chan, ifp.c_ready, ifp.m_first, ifp.m_last, ifp.m_data, ifp.m_mask);
        end
        @(posedge clk); #1;
        c_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ifp.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_a_drain got v%b expected 0", ifp.m_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_priority();
        logic exp_r;
        do_reset();
        a_valid = 1'b1; a_opcode = 3'd4; a_size = 4'd2;
        c_valid = 1'b1; c_opcode = 3'd4; c_size = 4'd6;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ifp.m_chan !== 1'b1 || ifp.c_ready !== 1'b1 || ifp.a_ready !== 1'b0) begin
                errors++;
                $display("FAIL prio_c_wins%0d got ch%b cr%b ar%b expected 1 1 0", i, ifp.m_chan, ifp.c_ready, ifp.a_ready);
            end
            exp_r = (i % 2 == 0);
            checks++;
            if (ifr.m_chan !== exp_r || ifr.m_last !== 1'b1) begin
                errors++;
                $display("FAIL rr_alternate%0d got ch%b l%b expected %b 1", i, ifr.m_chan, ifr.m_last, exp_r);
            end
            @(posedge clk); #1;
        end
        a_valid = 1'b0; c_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_release_toggle();
        int hs;
        logic exp_first, exp_last;
        hs = 0;
        a_valid = 1'b1; a_opcode = 3'd4; a_size = 4'd2;
        c_valid = 1'b1; c_opcode = 3'd7; c_size = 4'd6; c_data = 32'h0;
        m_ready = 1'b0;
        for (int cyc = 0; cyc < 64 && hs < 16; cyc++) begin
            m_ready = (cyc % 2 == 1);
            @(negedge clk);
            exp_first = (hs == 0);
            exp_last  = (hs == 15);
            checks++;
            if (ifp.m_chan !== 1'b1 || ifp.m_mask !== 4'hF || ifp.a_ready !== 1'b0 || ifp.c_ready !== m_ready ||
                ifp.m_data !== 32'(hs) || ifp.m_first !== exp_first || ifp.m_last !== exp_last) begin
                errors++;
                $display("FAIL release_cyc%0d got ch%b mask%h ar%b cr%b d%h f%b l%b expected 1 f 0 %b %h %b %b",
                         cyc, ifp.m_chan, ifp.m_mask, ifp.a_ready, ifp.c_ready, ifp.m_data, ifp.m_first, ifp.m_last,
                         m_ready, 32'(hs), exp_first, exp_last);
            end
            if (ifp.m_valid && m_ready) hs++;
            @(posedge clk); #1;
            c_data = 32'(hs);
        end
        checks++;
        if (hs != 16) begin
            errors++;
            $display("FAIL release_count got %0d handshakes expected 16", hs);
        end
        c_valid = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ifp.m_chan !== 1'b0 || ifp.a_ready !== 1'b1 || ifp.m_valid !== 1'b1) begin
            errors++;
            $display("FAIL release_then_a got ch%b ar%b v%b expected 0 1 1", ifp.m_chan, ifp.a_ready, ifp.m_valid);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        logic exp_ar;
        a_valid = 1'b1; a_opcode = 3'd0; a_size = 4'd2; a_address = 32'h8000; a_data = 32'hAAAA5555;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                c_valid = 1'b1; c_opcode = 3'd4; c_size = 4'd6; c_data = 32'h5A5A;
            end
            if (i == 5) m_ready = 1'b1;
            @(negedge clk);
            exp_ar = (i == 5);
            checks++;
            if (ifp.m_valid !== 1'b1 || ifp.m_chan !== 1'b0 || ifp.m_data !== 32'hAAAA5555 ||
                ifp.m_last !== 1'b1 || ifp.a_ready !== exp_ar || ifp.c_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cyc%0d got v%b ch%b d%h l%b ar%b cr%b expected 1 0 aaaa5555 1 %b 0",
                         i, ifp.m_valid, ifp.m_chan, ifp.m_data, ifp.m_last, ifp.a_ready, ifp.c_ready, exp_ar);
            end
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ifp.m_chan !== 1'b1 || ifp.c_ready !== 1'b1 || ifp.m_data !== 32'h5A5A) begin
            errors++;
            $display("FAIL hold_then_c got ch%b cr%b d%h expected 1 1 00005a5a", ifp.m_chan, ifp.c_ready, ifp.m_data);
        end
        @(posedge clk); #1;
        c_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_oversize();
        a_valid = 1'b1; a_opcode = 3'd0; a_size = 4'd8; a_data = 32'h0;
        m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (err_p !== 1'b0 || ifp.m_last !== 1'b0 || ifp.m_first !== 1'b1) begin
            errors++;
            $display("FAIL oversize_first got err%b l%b f%b expected 0 0 1", err_p, ifp.m_last, ifp.m_first);
        end
        for (int i = 1; i < 5; i++) begin
            @(posedge clk); #1;
            a_data = 32'(i);
            @(negedge clk);
            checks++;
            if (err_p !== 1'b1 || ifp.m_first !== 1'b0 || ifp.m_last !== 1'b0) begin
                errors++;
                $display("FAIL oversize_beat%0d got err%b f%b l%b expected 1 0 0", i, err_p, ifp.m_first, ifp.m_last);
            end
        end
        #1;
        rstnn = 1'b0;
        a_valid = 1'b0;
        #1;
        checks++;
        if ({ifp.m_valid, ifp.a_ready, ifp.c_ready, ifp.m_first, ifp.m_last, ifp.m_chan, err_p} !== 7'b0001000) begin
            errors++;
            $display("FAIL midburst_reset got v%b ar%b cr%b f%b l%b ch%b err%b expected 0 0 0 1 0 0 0",
                     ifp.m_valid, ifp.a_ready, ifp.c_ready, ifp.m_first, ifp.m_last, ifp.m_chan, err_p);
        end
        @(posedge clk); #1;
        rstnn = 1'b1;
        c_valid = 1'b1; c_opcode = 3'd4; c_size = 4'd6;
        @(negedge clk);
        checks++;
        if (ifp.m_chan !== 1'b1 || ifp.m_first !== 1'b1 || ifp.m_last !== 1'b1 || ifp.c_ready !== 1'b1 || err_p !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_c got ch%b f%b l%b cr%b err%b expected 1 1 1 1 0",
                     ifp.m_chan, ifp.m_first, ifp.m_last, ifp.c_ready, err_p);
        end
        @(posedge clk); #1;
        c_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rstnn = 1'b0;
        test_reset();
        test_single_get();
        test_burst_a();
        test_priority();
        test_release_toggle();
        test_hold();
        test_oversize();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
